// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: state encoding and parity mode codes shared by the UART transmitter.
package uart_tx_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;
  localparam state_t BREAK  = 3'd5;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter; bit_tick marks the last clk of each bit, clear re-aligns the phase.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] clk_cnt;
  assign bit_tick = clk_cnt == LAST;
  always_ff @(posedge clk)
    clk_cnt <= (reset || clear || bit_tick) ? '0 : clk_cnt + 1'b1;
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter with per-frame parity/stop format; line break generation when UART_TX_BREAK_EN is defined.
module uart_tx_core import uart_tx_pkg::*; #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int BREAK_BITS   = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 send_break,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  localparam int BW = $clog2(DATA_BITS);
  state_t state, nxt;
  logic [DATA_BITS-1:0] sh, sh_nxt;
  logic [BW-1:0] bit_idx;
  logic stop_idx, par_en, par, two_q, tick, accept, last_bit, last_stop, frame_done, tx_nxt;
  logic start_brk, brk_done, brk_low;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk), .reset(reset), .clear(state == IDLE || accept), .bit_tick(tick)
  );
  assign accept     = valid_in && ready_out;
  assign last_bit   = bit_idx == BW'(DATA_BITS - 1);
  assign last_stop  = !two_q || stop_idx;
  assign frame_done = state == STOP && tick && last_stop;
`ifdef UART_TX_BREAK_EN
  localparam int KW = $clog2(BREAK_BITS + 1);
  logic [KW-1:0] brk_cnt, brk_nxt;
  assign start_brk = state == IDLE && !valid_in && send_break;
  assign brk_done  = state == BREAK && tick && brk_cnt == KW'(BREAK_BITS);
  assign brk_nxt   = (state == BREAK && tick) ? (brk_done ? '0 : brk_cnt + 1'b1) : brk_cnt;
  // Line stays low for BREAK_BITS periods, then one mark period before done.
  assign brk_low   = brk_nxt != KW'(BREAK_BITS);
  always_ff @(posedge clk) brk_cnt <= reset ? '0 : brk_nxt;
`else
  logic unused_ok;
  assign {start_brk, brk_done, brk_low} = '0;
  assign unused_ok = send_break | (BREAK_BITS == 0);
`endif
  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? START : start_brk ? BREAK : IDLE;
      START:   nxt = tick ? DATA : START;
      DATA:    nxt = (tick && last_bit) ? (par_en ? PARITY : STOP) : DATA;
      PARITY:  nxt = tick ? STOP : PARITY;
      STOP:    nxt = frame_done ? (accept ? START : IDLE) : STOP;
      BREAK:   nxt = brk_done ? IDLE : BREAK;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    ready_out = !reset && (state == IDLE || frame_done);
    busy      = state != IDLE;
    done      = frame_done || brk_done;
    sh_nxt    = accept ? data_in : (state == DATA && tick) ? sh >> 1 : sh;
    tx_nxt    = nxt == START  ? 1'b0 :
                nxt == DATA   ? sh_nxt[0] :
                nxt == PARITY ? par :
                nxt == BREAK  ? !brk_low : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tx       <= 1'b1;
      sh       <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_en   <= 1'b0;
      par      <= 1'b0;
      two_q    <= 1'b0;
    end else begin
      tx <= tx_nxt;
      sh <= sh_nxt;
      if (accept) begin
        par_en <= parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
        par    <= (parity_mode == PAR_ODD) ^ (^data_in);
        two_q  <= two_stop;
      end
      if (state == DATA && tick) bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
      if (state == STOP && tick) stop_idx <= !last_stop;
    end
  end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed and randomized frames checked clk-by-clk against a bit-list frame model.
module tb_uart_tx_core;
  logic clk = 0, reset = 1, valid_in = 0, two_stop = 0, send_break = 0;
  logic [7:0] data_in = '0;
  logic [1:0] parity_mode = '0;
  logic ready_out, tx, busy, done;
  int checks = 0, failures = 0;
  uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(4), .BREAK_BITS(13)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .parity_mode(parity_mode), .two_stop(two_stop), .send_break(send_break),
    .tx(tx), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic offer(input logic [7:0] d, input logic [1:0] m, input logic ts);
    @(negedge clk);
    {data_in, parity_mode, two_stop, valid_in} = {d, m, ts, 1'b1};
    chk("ready_idle", ready_out, 1);
  endtask
  // Accept edge is the next posedge; checks every clk of the frame against the expected bit list.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] m, input logic ts, input bit scr,
                           input bit chain, input logic [7:0] nd, input logic [1:0] nm, input logic nts);
    logic eb[12];
    int n = 0, len;
    eb[n++] = 0;
    for (int i = 0; i < 8; i++) eb[n++] = d[i];
    if (m == 2'b01) eb[n++] = ^d;
    else if (m == 2'b10) eb[n++] = ~^d;
    eb[n++] = 1;
    if (ts) eb[n++] = 1;
    len = n * 4;
    @(posedge clk);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      chk("tx", tx, eb[(k-1)/4]);
      chk("busy", busy, 1);
      chk("done", done, k == len);
      chk("ready", ready_out, k == len);
      if (chain) begin
        if (k == 2) {data_in, parity_mode, two_stop} = {nd, nm, nts};
      end else begin
        valid_in = 0;
        if (scr) {data_in, parity_mode, two_stop} = {8'($urandom), 2'($urandom), 1'($urandom)};
      end
    end
  endtask
  task automatic idle_check(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_ready", ready_out, 1);
    end
  endtask
  initial begin
    logic [7:0] cd, nd;
    logic [1:0] cm, nm;
    logic cts, nts;
    bit ch;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready_out, 0);
    reset = 0;
    idle_check(2);
    offer(8'hA5, 2'b00, 0); run_frame(8'hA5, 2'b00, 0, 0, 0, 0, 0, 0);
    idle_check(1);
    offer(8'h03, 2'b01, 0); run_frame(8'h03, 2'b01, 0, 0, 0, 0, 0, 0);
    offer(8'h03, 2'b10, 0); run_frame(8'h03, 2'b10, 0, 0, 0, 0, 0, 0);
    offer(8'h03, 2'b11, 0); run_frame(8'h03, 2'b11, 0, 0, 0, 0, 0, 0);
    offer(8'h03, 2'b01, 1); run_frame(8'h03, 2'b01, 1, 0, 0, 0, 0, 0);
    offer(8'h55, 2'b00, 0); run_frame(8'h55, 2'b00, 0, 0, 1, 8'hAA, 2'b10, 0);
    run_frame(8'hAA, 2'b10, 0, 0, 0, 0, 0, 0);
    idle_check(1);
    offer(8'h3C, 2'b00, 0);
    @(posedge clk);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      valid_in = 0;
      chk("pre_rst_busy", busy, 1);
    end
    reset = 1;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", ready_out, 0);
    reset = 0;
    idle_check(2);
    offer(8'h0F, 2'b00, 0); run_frame(8'h0F, 2'b00, 0, 0, 0, 0, 0, 0);
    offer(8'h3C, 2'b01, 1); run_frame(8'h3C, 2'b01, 1, 1, 0, 0, 0, 0);
    offer(8'hC3, 2'b10, 0); run_frame(8'hC3, 2'b10, 0, 1, 0, 0, 0, 0);
    idle_check(1);
`ifdef UART_TX_BREAK_EN
    @(negedge clk);
    send_break = 1;
    @(posedge clk);
    for (int k = 1; k <= 56; k++) begin
      @(negedge clk);
      send_break = 0;
      chk("brk_tx", tx, k > 52);
      chk("brk_busy", busy, 1);
      chk("brk_ready", ready_out, 0);
      chk("brk_done", done, k == 56);
    end
    idle_check(2);
`else
    @(negedge clk);
    send_break = 1;
    idle_check(20);
    send_break = 0;
`endif
    {cd, cm, cts} = {8'($urandom), 2'($urandom), 1'($urandom)};
    offer(cd, cm, cts);
    for (int i = 0; i < 20; i++) begin
      {nd, nm, nts} = {8'($urandom), 2'($urandom), 1'($urandom)};
      ch = (i < 19) && ($urandom_range(0, 1) == 1);
      run_frame(cd, cm, cts, !ch && ($urandom_range(0, 1) == 1), ch, nd, nm, nts);
      if (!ch && i < 19) begin
        idle_check($urandom_range(1, 3));
        offer(nd, nm, nts);
      end
      {cd, cm, cts} = {nd, nm, nts};
    end
    idle_check(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
